aio_ram_check: RTL and testbench

AIO_RAM_CHECK -- requirements
Module: aio_ram_check

---
 rtl/aio_init_pkg.sv | 22 ++
 rtl/aio_ram_check_if.sv | 14 +
 rtl/aio_ram_chk_pat_gen.sv | 29 ++
 rtl/aio_ram_check.sv | 129 ++++++++++++
 tb/tb_aio_ram_check.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/aio_init_pkg.sv
// Shared init-sequencer definitions: RAM checker state encoding and default test word.
package aio_init_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [15:0] DEF_PATTERN = 16'hA5C3;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ,
    S_FLUSH = ST_FLUSH,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } chk_state_e;

endpackage

// File: rtl/aio_ram_check_if.sv
// RAM access bus between the RAM checker (master) and the RAM under test (slave).
interface aio_ram_check_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_rdata;

  modport master (output ram_addr, ram_wr_en, ram_wdata, ram_rd_en, input ram_rdata);
  modport slave  (input ram_addr, ram_wr_en, ram_wdata, ram_rd_en, output ram_rdata);
endinterface

// File: rtl/aio_ram_chk_pat_gen.sv
// Address counter and expected-word generator; pass_sel picks PATTERN or ~PATTERN.
module aio_ram_chk_pat_gen #(
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] PATTERN = '0
) (
  input  logic              sys_clk,
  input  logic              glbl_rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              pass_sel,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q;

  // Natural wrap at N-1 hands the next phase a counter already at 0.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n)  addr_q <= '0;
    else if (clr)     addr_q <= '0;
    else if (inc)     addr_q <= addr_q + ADDR_W'(1);
  end

  assign addr = addr_q;
  assign last = &addr_q;
  assign word = (pass_sel ? ~PATTERN : PATTERN) ^ DATA_W'(addr_q);

endmodule

// File: rtl/aio_ram_check.sv
// RAM self-test: write pat^addr to every location, read back and compare.
// Define AIO_RAM_CHK_INV_PASS_EN to add a second pass with pat = ~PATTERN.
//
// state | meaning
// IDLE  | waiting for check_ram_en
// WRITE | writing pattern to addr 0..N-1
// READ  | reading addr 0..N-1, comparing previous read
// FLUSH | comparing final read
// DONE  | one-cycle pass pulse
// ERR   | one-cycle fail pulse, err_addr valid
module aio_ram_check
  import aio_init_pkg::*;
#(
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
  input  logic              sys_clk,
  input  logic              glbl_rst_n,
  input  logic              check_ram_en,
  output logic              check_ram_done,
  output logic              check_ram_error,
  output logic [ADDR_W-1:0] err_addr,
  output logic              busy,
  aio_ram_check_if.master   ram
);
`ifdef AIO_RAM_CHK_INV_PASS_EN
  localparam bit INV_PASS = 1'b1;
`else
  localparam bit INV_PASS = 1'b0;
`endif

  chk_state_e        state_q, state_d;
  logic              pass_q, pass_d;
  logic              cnt_clr, wr_en, rd_en, mismatch, last;
  logic              cmp_vld_q;
  logic [ADDR_W-1:0] addr, exp_addr_q;
  logic [DATA_W-1:0] word, exp_word_q;

  aio_ram_chk_pat_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PATTERN(PATTERN)
  ) u_pat_gen (
    .sys_clk   (sys_clk),
    .glbl_rst_n(glbl_rst_n),
    .clr       (cnt_clr),
    .inc       (wr_en | rd_en),
    .pass_sel  (pass_q),
    .addr      (addr),
    .word      (word),
    .last      (last)
  );

  assign mismatch = cmp_vld_q && (state_q == S_READ || state_q == S_FLUSH) &&
                    (ram.ram_rdata != exp_word_q);

  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    cnt_clr = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: if (check_ram_en) begin
        state_d = S_WRITE;
        pass_d  = 1'b0;
        cnt_clr = 1'b1;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (last) state_d = S_READ;
      end
      S_READ: begin
        rd_en = 1'b1;
        if (mismatch)  state_d = S_ERR;
        else if (last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (mismatch) state_d = S_ERR;
        else if (INV_PASS && !pass_q) begin
          state_d = S_WRITE;
          pass_d  = 1'b1;
          cnt_clr = 1'b1;
        end else state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One-deep compare pipeline: read data returns the cycle after the strobe.
  always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
    if (!glbl_rst_n) begin
      cmp_vld_q  <= 1'b0;
      exp_addr_q <= '0;
      exp_word_q <= '0;
      err_addr   <= '0;
    end else begin
      cmp_vld_q <= rd_en;
      if (rd_en) begin
        exp_addr_q <= addr;
        exp_word_q <= word;
      end
      if (state_q == S_IDLE && check_ram_en) err_addr <= '0;
      else if (mismatch)                     err_addr <= exp_addr_q;
    end
  end

  assign ram.ram_wr_en    = wr_en;
  assign ram.ram_rd_en    = rd_en;
  assign ram.ram_addr     = (wr_en | rd_en) ? addr : '0;
  assign ram.ram_wdata    = wr_en ? word : '0;
  assign check_ram_done   = (state_q == S_DONE);
  assign check_ram_error  = (state_q == S_ERR);
  assign busy             = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_aio_ram_check.sv
// Bench for aio_ram_check: RAM model with injectable stuck-at cell, transaction scoreboard.
module tb_aio_ram_check;
  localparam int            AW  = 4;
  localparam int            DW  = 16;
  localparam int            N   = 16;
  localparam logic [DW-1:0] PAT = 16'hA5C3;
`ifdef AIO_RAM_CHK_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          sys_clk = 1'b0;
  logic          glbl_rst_n;
  logic          check_ram_en;
  logic          check_ram_done;
  logic          check_ram_error;
  logic          busy;
  logic [AW-1:0] err_addr;

  aio_ram_check_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

  aio_ram_check #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(PAT)) dut (
    .sys_clk        (sys_clk),
    .glbl_rst_n     (glbl_rst_n),
    .check_ram_en   (check_ram_en),
    .check_ram_done (check_ram_done),
    .check_ram_error(check_ram_error),
    .err_addr       (err_addr),
    .busy           (busy),
    .ram            (rif)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM model: one-cycle read latency, optional stuck-at cell on read.
  logic [DW-1:0] mem [N];
  int            f_addr = -1;
  logic [DW-1:0] f_and  = '1;
  logic [DW-1:0] f_or   = '0;

  always @(posedge sys_clk) begin
    if (rif.ram_wr_en) mem[rif.ram_addr] <= rif.ram_wdata;
    if (rif.ram_rd_en)
      rif.ram_rdata <= (int'(rif.ram_addr) == f_addr) ?
                       ((mem[rif.ram_addr] & f_and) | f_or) : mem[rif.ram_addr];
  end

  txn_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bus transactions and pulse cycles (cycle 0 = edge sampling en).
  task automatic build_expect(output int done_c, output int err_c, output int err_a);
    logic [DW-1:0] pat, w, r;
    bit stop;
    exp_q.delete();
    err_c = -1;
    err_a = 0;
    stop  = 1'b0;
    for (int p = 0; p < PASSES && !stop; p++) begin
      pat = (p == 0) ? PAT : ~PAT;
      for (int a = 0; a < N; a++) exp_q.push_back('{1'b1, AW'(a), pat ^ DW'(a)});
      for (int a = 0; a < N && !stop; a++) begin
        exp_q.push_back('{1'b0, AW'(a), '0});
        w = pat ^ DW'(a);
        r = (a == f_addr) ? ((w & f_and) | f_or) : w;
        if (r !== w) begin
          stop  = 1'b1;
          err_c = 19 + a + 33 * p;
          err_a = a;
          if (a < N - 1) exp_q.push_back('{1'b0, AW'(a + 1), '0});
        end
      end
    end
    done_c = stop ? -1 : 33 * PASSES + 1;
  endtask

  task automatic run(input string tag, input int extra_en, input int rst_at);
    int            done_c, err_c, err_a, end_c, done_obs, err_obs, n_extra, n_bad;
    logic [AW-1:0] ea_obs;
    txn_t          e;
    build_expect(done_c, err_c, err_a);
    end_c    = (err_c >= 0) ? err_c : done_c;
    done_obs = -1;
    err_obs  = -1;
    n_extra  = 0;
    n_bad    = 0;
    ea_obs   = '0;
    @(negedge sys_clk) check_ram_en = 1'b1;
    @(negedge sys_clk) check_ram_en = 1'b0;
    for (int k = 1; k <= end_c + 2; k++) begin
      if (k == rst_at) begin
        glbl_rst_n = 1'b0;
        #1;
        check({tag, "_rst_ctrl"}, 32'({check_ram_done, check_ram_error, busy, err_addr}), 32'd0);
        check({tag, "_rst_bus"},
              32'({rif.ram_wr_en, rif.ram_rd_en, rif.ram_addr, rif.ram_wdata}), 32'd0);
        @(negedge sys_clk) glbl_rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (rif.ram_wr_en && rif.ram_rd_en)       n_bad++;
      if (check_ram_done && check_ram_error)    n_bad++;
      if (busy !== (k < end_c))                 n_bad++;
      if (rif.ram_wr_en || rif.ram_rd_en) begin
        if (exp_q.size() == 0) n_extra++;
        else begin
          e = exp_q.pop_front();
          check({tag, "_kind"}, 32'(rif.ram_wr_en), 32'(e.wr));
          check({tag, "_addr"}, 32'(rif.ram_addr), 32'(e.addr));
          if (e.wr) check({tag, "_wdata"}, 32'(rif.ram_wdata), 32'(e.data));
        end
      end
      if (check_ram_done && done_obs < 0) done_obs = k;
      if (check_ram_error && err_obs < 0) begin
        err_obs = k;
        ea_obs  = err_addr;
      end
      if (k == 1) check({tag, "_erraddr_clr"}, 32'(err_addr), 32'd0);
      check_ram_en = (k == extra_en);
      @(negedge sys_clk);
    end
    check({tag, "_done_cyc"}, 32'(done_obs), 32'(done_c));
    check({tag, "_err_cyc"}, 32'(err_obs), 32'(err_c));
    if (err_c >= 0) begin
      check({tag, "_err_addr"}, 32'(ea_obs), 32'(err_a));
      check({tag, "_err_addr_hold"}, 32'(err_addr), 32'(err_a));
    end
    check({tag, "_missing_txn"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_extra_txn"}, 32'(n_extra), 32'd0);
    check({tag, "_protocol"}, 32'(n_bad), 32'd0);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int n_act;
    n_act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sys_clk);
      if (busy || rif.ram_wr_en || rif.ram_rd_en || check_ram_done || check_ram_error) n_act++;
    end
    check({tag, "_idle"}, 32'(n_act), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    glbl_rst_n   = 1'b0;
    check_ram_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("reset_ctrl", 32'({check_ram_done, check_ram_error, busy, err_addr}), 32'd0);
    check("reset_bus", 32'({rif.ram_wr_en, rif.ram_rd_en, rif.ram_addr, rif.ram_wdata}), 32'd0);
    glbl_rst_n = 1'b1;
    idle_check("post_reset", 4);

    run("clean", 0, 0);

    f_addr = 5; f_and = ~16'h0002; f_or = '0;
    run("sa0_b1_a5", 0, 0);
    f_and = ~16'h0008;
    run("sa0_b3_a5", 0, 0);

    f_addr = -1; f_and = '1; f_or = '0;
    run("clean_after_err", 0, 0);
    run("en_ignored", 10, 0);

    run("rst_mid", 0, 20);
    idle_check("after_rst", 5);
    run("rerun", 0, 0);

    f_addr = 2; f_and = '1; f_or = 16'h0001;
    run("sa1_b0_a2", 0, 0);

    f_addr = -1; f_or = '0;
    run("final_clean", 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
